// File: rtl/softex_pkg.sv
// Shared types and constants for the softex streamer load-side pad stage.
package softex_pkg;

    localparam int unsigned DATA_W = 128;

    localparam logic [15:0] BF16_NEG_INF = 16'hFF80;

    typedef struct packed {
        logic [31:0] vec_len;
        logic [31:0] num_vec;
    } ld_pad_cfg_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } ld_pad_state_e;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream bundle between the HCI streamer and the datapath.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                      valid;
    logic                      ready;
    logic [DATA_WIDTH-1:0]     data;
    logic [DATA_WIDTH/8-1:0]   strb;

    modport source (
        output valid, data, strb,
        input  ready
    );

    modport sink (
        input  valid, data, strb,
        output ready
    );

endinterface

// File: rtl/softex_ld_pad_mask.sv
// Combinational lane mask: replaces element lanes past the vector tail
// with PAD and clears their strobe bits.
module softex_ld_pad_mask #(
    parameter int unsigned   DW  = 128,
    parameter int unsigned   EW  = 16,
    parameter int unsigned   LB  = $clog2(DW/8),
    parameter logic [EW-1:0] PAD = '1
) (
    input  logic [DW-1:0]   data_i,
    input  logic [LB-1:0]   lftovr_i,
    input  logic            pad_en_i,
    output logic [DW-1:0]   data_o,
    output logic [DW/8-1:0] strb_o
);

    localparam int unsigned NE = DW / EW;
    localparam int unsigned EB = EW / 8;

    logic [NE-1:0] lane_valid;

    // A lane survives only if every one of its bytes is inside the vector.
    for (genvar k = 0; k < NE; k++) begin : g_lane
        assign lane_valid[k] = ~pad_en_i |
                               (32'((k + 1) * EB) <= 32'(lftovr_i));
        assign data_o[k*EW +: EW] = lane_valid[k] ? data_i[k*EW +: EW]
                                                  : PAD;
        assign strb_o[k*EB +: EB] = {EB{lane_valid[k]}};
    end

endmodule

// File: rtl/softex_streamer_ld_pad.sv
// Load-side tail padder and last-beat tagger for the softex streamer.
// Optional output register: define SOFTEX_LD_PAD_OUT_REG_EN.
module softex_streamer_ld_pad
    import softex_pkg::*;
#(
    parameter int unsigned   DW  = DATA_W,
    parameter int unsigned   EW  = 16,
    parameter logic [EW-1:0] PAD = EW'(BF16_NEG_INF)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        start_i,
    input  logic [31:0] vec_len_i,
    input  logic [31:0] num_vec_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        vec_last_o,
    output logic        job_last_o,
    hwpe_stream_intf_stream.sink   stream_i,
    hwpe_stream_intf_stream.source stream_o
);

    localparam int unsigned LB = $clog2(DW/8);

    ld_pad_cfg_t   cfg;
    ld_pad_state_e state_q;
    logic [LB-1:0] lftovr_q;
    logic [31:0]   bpv_q;
    logic [31:0]   num_vec_q;
    logic [31:0]   beat_cnt_q;
    logic [31:0]   vec_cnt_q;
    logic          busy_q;
    logic          done_q;

    logic          run;
    logic          vec_last;
    logic          job_last;
    logic          in_ready;
    logic          in_hs;
    logic          fin;
    logic [DW-1:0]   pad_data;
    logic [DW/8-1:0] pad_strb;

    assign cfg      = '{vec_len: vec_len_i, num_vec: num_vec_i};
    assign run      = (state_q == RUN);
    assign vec_last = (beat_cnt_q == bpv_q - 32'd1);
    assign job_last = vec_last & (vec_cnt_q == num_vec_q - 32'd1);
    assign in_hs    = stream_i.valid & in_ready;

    assign stream_i.ready = in_ready;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

    softex_ld_pad_mask #(
        .DW  (DW),
        .EW  (EW),
        .LB  (LB),
        .PAD (PAD)
    ) i_mask (
        .data_i   (stream_i.data),
        .lftovr_i (lftovr_q),
        .pad_en_i (vec_last & (|lftovr_q)),
        .data_o   (pad_data),
        .strb_o   (pad_strb)
    );

`ifdef SOFTEX_LD_PAD_OUT_REG_EN
    logic            out_valid_q;
    logic [DW-1:0]   out_data_q;
    logic [DW/8-1:0] out_strb_q;
    logic            out_vl_q;
    logic            out_jl_q;
    logic            jl_in_q;
    logic            out_hs;

    assign out_hs   = out_valid_q & stream_o.ready;
    // Once the job tail is captured, no more input until it drains.
    assign in_ready = run & ~jl_in_q & (~out_valid_q | stream_o.ready);
    assign fin      = out_hs & out_jl_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_strb_q  <= '0;
            out_vl_q    <= 1'b0;
            out_jl_q    <= 1'b0;
            jl_in_q     <= 1'b0;
        end else if (clear_i) begin
            out_valid_q <= 1'b0;
            out_vl_q    <= 1'b0;
            out_jl_q    <= 1'b0;
            jl_in_q     <= 1'b0;
        end else begin
            if (in_hs) begin
                out_valid_q <= 1'b1;
                out_data_q  <= pad_data;
                out_strb_q  <= pad_strb;
                out_vl_q    <= vec_last;
                out_jl_q    <= job_last;
            end else if (out_hs) begin
                out_valid_q <= 1'b0;
            end
            if (in_hs & job_last) begin
                jl_in_q <= 1'b1;
            end else if (fin) begin
                jl_in_q <= 1'b0;
            end
        end
    end

    assign stream_o.valid = out_valid_q;
    assign stream_o.data  = out_data_q;
    assign stream_o.strb  = out_strb_q;
    assign vec_last_o     = out_valid_q & out_vl_q;
    assign job_last_o     = out_valid_q & out_jl_q;
`else
    assign in_ready       = run & stream_o.ready;
    assign fin            = in_hs & job_last;
    assign stream_o.valid = run & stream_i.valid;
    assign stream_o.data  = pad_data;
    assign stream_o.strb  = pad_strb;
    assign vec_last_o     = run & vec_last;
    assign job_last_o     = run & job_last;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            lftovr_q   <= '0;
            bpv_q      <= '0;
            num_vec_q  <= '0;
            beat_cnt_q <= '0;
            vec_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (clear_i) begin
            state_q    <= IDLE;
            lftovr_q   <= '0;
            bpv_q      <= '0;
            num_vec_q  <= '0;
            beat_cnt_q <= '0;
            vec_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        lftovr_q   <= cfg.vec_len[LB-1:0];
                        bpv_q      <= (cfg.vec_len >> LB) +
                                      32'(|cfg.vec_len[LB-1:0]);
                        num_vec_q  <= cfg.num_vec;
                        beat_cnt_q <= '0;
                        vec_cnt_q  <= '0;
                        busy_q     <= 1'b1;
                        if (cfg.vec_len == '0 || cfg.num_vec == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (in_hs) begin
                        if (vec_last) begin
                            beat_cnt_q <= '0;
                            vec_cnt_q  <= vec_cnt_q + 32'd1;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 32'd1;
                        end
                    end
                    if (fin) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
